// File: rtl/corefifo_pkg.sv
// Shared CoreFIFO helpers: pointer width, Gray/binary conversion and synchronizer depth limits.
package corefifo_pkg;

  localparam int unsigned SyncStagesMin = 2;
  localparam int unsigned SyncStagesMax = 4;

  // Conversion helpers operate on a wide container; callers zero-extend and truncate.
  localparam int unsigned MaxPtrW = 32;
  typedef logic [MaxPtrW-1:0] ptr_max_t;

  function automatic int unsigned ptr_width(input int unsigned addrwidth);
    return addrwidth + 1;
  endfunction

  function automatic ptr_max_t bin_to_gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_max_t gray_to_bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[MaxPtrW-1] = gray[MaxPtrW-1];
    for (int i = MaxPtrW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/corefifo_bin_to_gray_wptr_if.sv
// Write-port bundle of the CoreFIFO write pointer block; slave is the pointer block itself.
interface corefifo_bin_to_gray_wptr_if #(
  parameter int unsigned ADDRWIDTH = 3
);
  logic                 we;
  logic [ADDRWIDTH:0]   rd_gray;
  logic [ADDRWIDTH-1:0] waddr;
  logic [ADDRWIDTH:0]   wr_gray;
  logic                 wr_en_ram;
  logic                 full;
  logic                 afull;
  logic [ADDRWIDTH:0]   wcount;
  logic                 wr_ack;
  logic                 overflow;

  modport master (
    output we, rd_gray,
    input  waddr, wr_gray, wr_en_ram, full, afull, wcount, wr_ack, overflow
  );

  modport slave (
    input  we, rd_gray,
    output waddr, wr_gray, wr_en_ram, full, afull, wcount, wr_ack, overflow
  );
endinterface

// File: rtl/corefifo_ptr_sync.sv
// N-stage multi-bit flop synchronizer with synchronous active-low reset (Gray-coded inputs only).
module corefifo_ptr_sync
  import corefifo_pkg::*;
#(
  parameter int unsigned Width  = 4,
  parameter int unsigned Stages = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Stages < SyncStagesMin || Stages > SyncStagesMax) begin : g_bad_stages
    $error("corefifo_ptr_sync: Stages out of legal range");
  end

  logic [Stages-1:0][Width-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/corefifo_bin_to_gray_wptr.sv
// CoreFIFO write pointer: binary/Gray write pointer, synchronized read pointer, full/count flags.
// Define COREFIFO_AFULL_EN to build the almost-full comparator; otherwise afull is tied low.
module corefifo_bin_to_gray_wptr
  import corefifo_pkg::*;
#(
  parameter int unsigned ADDRWIDTH    = 3,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = 6
) (
  input logic                          clk,
  input logic                          reset_n,
  corefifo_bin_to_gray_wptr_if.slave   bus
);

  localparam int unsigned PtrW = ptr_width(ADDRWIDTH);
  // Full when the write Gray pointer equals the read Gray pointer with its top two bits inverted.
  localparam logic [PtrW-1:0] FullMask = PtrW'(2'b11) << (PtrW - 2);

  if (AFULL_THRESH < 1 || AFULL_THRESH > (1 << ADDRWIDTH)) begin : g_bad_thresh
    $error("corefifo_bin_to_gray_wptr: AFULL_THRESH out of range");
  end

  logic [PtrW-1:0] wbin_q, wbin_d;
  logic [PtrW-1:0] wgray_q, wgray_d;
  logic [PtrW-1:0] wcount_q, wcount_d;
  logic            full_q, full_d;
  logic            afull_q, afull_d;
  logic            ack_q, ovf_q;
  logic            push;
  logic [PtrW-1:0] rgray_s, rbin_s;

  corefifo_ptr_sync #(
    .Width  (PtrW),
    .Stages (SYNC_STAGES)
  ) u_rptr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (bus.rd_gray),
    .q_o     (rgray_s)
  );

  always_comb begin
    push     = bus.we & ~full_q;
    wbin_d   = wbin_q + PtrW'(push);
    wgray_d  = PtrW'(bin_to_gray(ptr_max_t'(wbin_d)));
    rbin_s   = PtrW'(gray_to_bin(ptr_max_t'(rgray_s)));
    wcount_d = wbin_d - rbin_s;
    full_d   = (wgray_d == (rgray_s ^ FullMask));
`ifdef COREFIFO_AFULL_EN
    afull_d  = (int unsigned'(wcount_d) >= AFULL_THRESH);
`else
    afull_d  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wcount_q <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wcount_q <= wcount_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ack_q    <= push;
      ovf_q    <= bus.we & full_q;
    end
  end

  assign bus.waddr     = wbin_q[ADDRWIDTH-1:0];
  assign bus.wr_gray   = wgray_q;
  assign bus.wr_en_ram = bus.we & ~full_q;
  assign bus.full      = full_q;
  assign bus.afull     = afull_q;
  assign bus.wcount    = wcount_q;
  assign bus.wr_ack    = ack_q;
  assign bus.overflow  = ovf_q;

endmodule
